// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//   - DEFAULT_TIMEOUT : default WAIT-cycle budget before an error is reported
//   - state_e         : sequencer FSM states (IDLE, FEED, WAIT)
//   - max_dim()       : number of DATA_WIDTH lanes packed in one operand word
//   - addr_width()    : operand word-index width, never narrower than 1 bit
//   - lane_lsb()      : low bit index of a lane inside a packed word
package matmul_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic int max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int addr_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Host-side handshake of the matrix-multiply sequencer.
//   master : host / register block (drives start_i, mode_i, abort_i)
//   slave  : sequencer (drives busy_o, done_o, err_o, flags_o, cycles_o)
// flags_o holds one overflow flag per PE; cycles_o is the WAIT-cycle count
// of the last completed operation.
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int CW        = $clog2(TIMEOUT + 1),
  localparam int FN        = MAX_DIM * MAX_DIM
);

  logic          start_i;
  logic          mode_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [FN-1:0] flags_o;
  logic [CW-1:0] cycles_o;

  modport master (
    output start_i, mode_i, abort_i,
    input  busy_o, done_o, err_o, flags_o, cycles_o
  );

  modport slave (
    input  start_i, mode_i, abort_i,
    output busy_o, done_o, err_o, flags_o, cycles_o
  );

endinterface

// File: rtl/skew_line.sv
// One lane of the diagonal skew: a DATA_WIDTH-wide shift register of DEPTH
// stages (DEPTH = 0 is a plain wire). clr_i empties every stage on the next
// clock edge.
//   clk_i : clock
//   clr_i : synchronous clear, active high
//   d_i   : lane data in
//   q_o   : lane data delayed DEPTH cycles
module skew_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // Lane 0 has no delay; clock and clear are deliberately left unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, clr_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
      end else begin
        stage_reg[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
      end
    end

    assign q_o = stage_reg[DEPTH-1];
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Runs one matrix multiply on a MAX_DIM x MAX_DIM systolic PE array.
// Reads A-column / B-row words k = 0..MAX_DIM-1 from two synchronous operand
// memories, skews lane i by i cycles onto the array buses, pulses the array
// start bit with the first lane-0 data, then waits for the array's done and
// reports completion (done_o, flags_o, cycles_o) or a timeout (err_o).
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   host                   : host handshake (start/mode/abort, busy/done/err,
//                            flags, cycles)
//   op_rd_en_o, op_addr_o  : operand memory read strobe and word index
//   a_word_i, b_word_i     : operand words, valid the cycle after the read
//   arr_a_o, arr_b_o       : skewed operand buses to the array
//   arr_start_o, arr_mode_o: array control bits
//   arr_done_i, arr_flags_i: array completion and overflow flags
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int AW        = addr_width(MAX_DIM),
  localparam int CW        = $clog2(TIMEOUT + 1),
  localparam int FN        = MAX_DIM * MAX_DIM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  matmul_sequencer_if.slave    host,
  output logic                 op_rd_en_o,
  output logic [AW-1:0]        op_addr_o,
  input  logic [BUS_WIDTH-1:0] a_word_i,
  input  logic [BUS_WIDTH-1:0] b_word_i,
  output logic [BUS_WIDTH-1:0] arr_a_o,
  output logic [BUS_WIDTH-1:0] arr_b_o,
  output logic                 arr_start_o,
  output logic                 arr_mode_o,
  input  logic                 arr_done_i,
  input  logic [FN-1:0]        arr_flags_i
);

  // FEED lasts 2*MAX_DIM cycles: MAX_DIM reads, then the skew drains.
  localparam int FW        = $clog2(2 * MAX_DIM);
  localparam int LAST_FEED = 2 * MAX_DIM - 1;

  state_e        state_reg, state_next;
  logic [FW-1:0] feed_cnt_reg, feed_cnt_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CW-1:0] wait_count;
  logic          mode_reg, mode_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [FN-1:0] flags_reg, flags_next;
  logic [CW-1:0] cycles_reg, cycles_next;
  logic          data_valid_reg;
  logic          abort_clr;
  logic          in_feed;

  // WAIT cycles used so far, counting the current one.
  assign wait_count = wait_cnt_reg + CW'(1);

  always_comb begin
    state_next    = state_reg;
    feed_cnt_next = feed_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    mode_next     = mode_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    flags_next    = flags_reg;
    cycles_next   = cycles_reg;
    abort_clr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // abort_i is meaningless here, so start always wins.
        if (host.start_i) begin
          state_next    = ST_FEED;
          mode_next     = host.mode_i;
          feed_cnt_next = '0;
        end
      end
      ST_FEED: begin
        if (host.abort_i) begin
          state_next = ST_IDLE;
          abort_clr  = 1'b1;
        end else if (feed_cnt_reg == FW'(LAST_FEED)) begin
          state_next    = ST_WAIT;
          wait_cnt_next = '0;
        end else begin
          feed_cnt_next = feed_cnt_reg + FW'(1);
        end
      end
      ST_WAIT: begin
        // Priority: abort, then done, then timeout.
        if (host.abort_i) begin
          state_next = ST_IDLE;
          abort_clr  = 1'b1;
        end else if (arr_done_i) begin
          state_next  = ST_IDLE;
          flags_next  = arr_flags_i;
          cycles_next = wait_count;
          done_next   = 1'b1;
        end else if (wait_count == CW'(TIMEOUT)) begin
          state_next  = ST_IDLE;
          cycles_next = wait_count;
          err_next    = 1'b1;
        end else begin
          wait_cnt_next = wait_count;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_IDLE) mode_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      feed_cnt_reg   <= '0;
      wait_cnt_reg   <= '0;
      mode_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      flags_reg      <= '0;
      cycles_reg     <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      feed_cnt_reg   <= feed_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      mode_reg       <= mode_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      flags_reg      <= flags_next;
      cycles_reg     <= cycles_next;
      // Memory data returns one cycle after each read.
      data_valid_reg <= op_rd_en_o & ~host.abort_i;
    end
  end

  assign in_feed     = (state_reg == ST_FEED);
  assign op_rd_en_o  = in_feed && (feed_cnt_reg < FW'(MAX_DIM));
  assign op_addr_o   = op_rd_en_o ? feed_cnt_reg[AW-1:0] : '0;
  // Second FEED cycle: the first word reaches lane 0.
  assign arr_start_o = in_feed && (feed_cnt_reg == FW'(1));
  assign arr_mode_o  = mode_reg;

  assign host.busy_o   = (state_reg != ST_IDLE);
  assign host.done_o   = done_reg;
  assign host.err_o    = err_reg;
  assign host.flags_o  = flags_reg;
  assign host.cycles_o = cycles_reg;

  // Gating before the skew lines means invalid slots travel down every lane
  // as zeros, so no per-lane valid tracking is needed.
  logic                 feed_valid;
  logic                 skew_clr;
  logic [BUS_WIDTH-1:0] a_gated, b_gated;

  assign feed_valid = data_valid_reg && in_feed;
  assign a_gated    = feed_valid ? a_word_i : '0;
  assign b_gated    = feed_valid ? b_word_i : '0;
  assign skew_clr   = ~rst_ni | abort_clr;

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, DATA_WIDTH);
    logic [DATA_WIDTH-1:0] a_skew, b_skew;

    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi)) u_skew_a (
      .clk_i (clk_i),
      .clr_i (skew_clr),
      .d_i   (a_gated[LSB +: DATA_WIDTH]),
      .q_o   (a_skew)
    );

    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi)) u_skew_b (
      .clk_i (clk_i),
      .clr_i (skew_clr),
      .d_i   (b_gated[LSB +: DATA_WIDTH]),
      .q_o   (b_skew)
    );

    assign arr_a_o[LSB +: DATA_WIDTH] = in_feed ? a_skew : '0;
    assign arr_b_o[LSB +: DATA_WIDTH] = in_feed ? b_skew : '0;
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer. Operand matrices live in the
// bench as plain 2-D arrays; expected bus contents come from the rule
// "lane i at cycle t carries element k = t-2-i", and expected handshake
// timing from the operation's start, done and abort cycles.
module tb_matmul_sequencer;

  localparam int BW = 16;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int M  = BW / DW;
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(TO + 1);
  localparam int FN = M * M;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_rd_en;
  logic [AW-1:0] op_addr;
  logic [BW-1:0] a_word = '0;
  logic [BW-1:0] b_word = '0;
  logic [BW-1:0] arr_a, arr_b;
  logic          arr_start, arr_mode;
  logic          arr_done = 1'b0;
  logic [FN-1:0] arr_flags = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FN-1:0] exp_flags = '0;
  logic [CW-1:0] exp_cycles = '0;

  int a_m [M][M];
  int b_m [M][M];

  always #5 clk = ~clk;

  matmul_sequencer_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT(TO)) host ();

  matmul_sequencer #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .host        (host),
    .op_rd_en_o  (op_rd_en),
    .op_addr_o   (op_addr),
    .a_word_i    (a_word),
    .b_word_i    (b_word),
    .arr_a_o     (arr_a),
    .arr_b_o     (arr_b),
    .arr_start_o (arr_start),
    .arr_mode_o  (arr_mode),
    .arr_done_i  (arr_done),
    .arr_flags_i (arr_flags)
  );

  // Synchronous operand memories: word k of A holds column k, of B row k.
  always @(posedge clk) begin
    if (op_rd_en) begin
      for (int i = 0; i < M; i++) begin
        a_word[i*DW +: DW] <= DW'(a_m[i][op_addr]);
        b_word[i*DW +: DW] <= DW'(b_m[op_addr][i]);
      end
    end
  end

  function automatic logic [BW-1:0] exp_a(input int t);
    logic [BW-1:0] w;
    int k;
    w = '0;
    for (int i = 0; i < M; i++) begin
      k = t - 2 - i;
      if (k >= 0 && k < M) w[i*DW +: DW] = DW'(a_m[i][k]);
    end
    return w;
  endfunction

  function automatic logic [BW-1:0] exp_b(input int t);
    logic [BW-1:0] w;
    int k;
    w = '0;
    for (int j = 0; j < M; j++) begin
      k = t - 2 - j;
      if (k >= 0 && k < M) w[j*DW +: DW] = DW'(b_m[k][j]);
    end
    return w;
  endfunction

  task automatic load_spec();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        a_m[i][k] = 1 + i * M + k;
        b_m[i][k] = 5 + i * M + k;
      end
  endtask

  task automatic load_rand();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        a_m[i][k] = int'($urandom_range(0, 255));
        b_m[i][k] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host.start_i = 1'b1;
    host.mode_i  = 1'b1;
    host.abort_i = 1'b0;
    arr_done  = 1'b1;
    arr_flags = '1;
    step();
    step();
    host.start_i = 1'b0;
    host.mode_i  = 1'b0;
    arr_done     = 1'b0;
    n_cmp++;
    if ({host.busy_o, host.done_o, host.err_o, host.flags_o, host.cycles_o, op_rd_en,
         op_addr, arr_a, arr_b, arr_start, arr_mode} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {host.busy_o, host.done_o, host.err_o,
               host.flags_o, host.cycles_o, op_rd_en, op_addr, arr_a, arr_b, arr_start, arr_mode});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({host.busy_o, host.done_o, host.err_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_release: got %b want 000", {host.busy_o, host.done_o, host.err_o});
    end
    exp_flags  = '0;
    exp_cycles = '0;
    $display("txn reset");
  endtask

  task automatic test_feed_done();
    int d;
    logic mode;
    logic [FN-1:0] fl;
    logic [BW-1:0] ea, eb;
    logic [BW-1:0] spec_a [5];
    logic [BW-1:0] spec_b [5];
    spec_a = '{16'h0000, 16'h0000, 16'h0001, 16'h0302, 16'h0400};
    spec_b = '{16'h0000, 16'h0000, 16'h0005, 16'h0607, 16'h0800};
    for (int r = 0; r < 6; r++) begin
      if (r == 0) begin
        load_spec();
        d = 2 * M + 4;
        fl = 4'b0100;
        mode = 1'b0;
      end else begin
        load_rand();
        d = (r == 1) ? 2 * M + TO : (r == 2) ? 2 * M + 1 : 2 * M + int'($urandom_range(1, 20));
        fl = FN'($urandom);
        mode = 1'($urandom_range(0, 1));
      end
      host.start_i = 1'b1;
      host.mode_i  = mode;
      arr_done     = 1'b0;
      for (int t = 1; t <= d + 1; t++) begin
        step();
        ea = exp_a(t);
        eb = exp_b(t);
        n_cmp++;
        if ({host.busy_o, host.done_o, host.err_o, op_rd_en, arr_start, arr_a, arr_b} !==
            {t <= d, t == d + 1, 1'b0, t <= M, t == 2, ea, eb}) begin
          n_bad++;
          $display("FAIL feed r%0d t%0d: got %h want %h", r, t,
                   {host.busy_o, host.done_o, host.err_o, op_rd_en, arr_start, arr_a, arr_b},
                   {t <= d, t == d + 1, 1'b0, t <= M, t == 2, ea, eb});
        end
        if (r == 0 && t >= 2 && t <= 4) begin
          n_cmp++;
          if (arr_a !== spec_a[t] || arr_b !== spec_b[t]) begin
            n_bad++;
            $display("FAIL spec_bus t%0d: got a=%h b=%h want a=%h b=%h", t, arr_a, arr_b,
                     spec_a[t], spec_b[t]);
          end
        end
        if (t <= M) begin
          n_cmp++;
          if (op_addr !== AW'(t - 1)) begin
            n_bad++;
            $display("FAIL op_addr r%0d t%0d: got %0d want %0d", r, t, op_addr, t - 1);
          end
        end
        if (t <= d) begin
          n_cmp++;
          if (arr_mode !== mode) begin
            n_bad++;
            $display("FAIL arr_mode r%0d t%0d: got %b want %b", r, t, arr_mode, mode);
          end
        end
        if (t == d) begin
          n_cmp++;
          if (host.flags_o !== exp_flags) begin
            n_bad++;
            $display("FAIL flags_hold r%0d: got %h want %h", r, host.flags_o, exp_flags);
          end
        end
        if (t == d + 1) begin
          exp_flags  = fl;
          exp_cycles = CW'(d - 2 * M);
          n_cmp++;
          if (host.flags_o !== exp_flags || host.cycles_o !== exp_cycles) begin
            n_bad++;
            $display("FAIL result r%0d: got flags=%h cycles=%0d want flags=%h cycles=%0d", r,
                     host.flags_o, host.cycles_o, exp_flags, exp_cycles);
          end
        end
        host.start_i = 1'b0;
        host.mode_i  = 1'($urandom_range(0, 1));
        arr_done     = (t == d) || (t <= 2 * M && $urandom_range(0, 1) == 1);
        arr_flags    = (t == d) ? fl : FN'($urandom);
      end
      arr_done = 1'b0;
      $display("txn feed r=%0d mode=%0d done_at=%0d flags=%h cycles=%0d", r, mode, d,
               host.flags_o, host.cycles_o);
    end
  endtask

  task automatic test_timeout();
    int te;
    te = 2 * M + TO + 1;
    load_rand();
    host.start_i = 1'b1;
    host.mode_i  = 1'b1;
    arr_done     = 1'b0;
    for (int t = 1; t <= te + 1; t++) begin
      step();
      n_cmp++;
      if ({host.busy_o, host.err_o, host.done_o} !== {t < te, t == te, 1'b0}) begin
        n_bad++;
        $display("FAIL timeout t%0d: got busy,err,done=%b want %b", t,
                 {host.busy_o, host.err_o, host.done_o}, {t < te, t == te, 1'b0});
      end
      host.start_i = 1'b0;
      arr_flags    = FN'($urandom);
    end
    n_cmp++;
    if (host.flags_o !== exp_flags) begin
      n_bad++;
      $display("FAIL timeout_flags: got %h want %h", host.flags_o, exp_flags);
    end
    $display("txn timeout err_at=%0d", te);
  endtask

  task automatic test_back_to_back();
    int d1, d2, b, rel;
    logic [FN-1:0] fl1, fl2;
    logic eb_busy, eb_done;
    d1 = 2 * M + 3;
    b  = d1 + 1;
    d2 = 2 * M + 2;
    fl1 = FN'($urandom);
    fl2 = ~fl1;
    load_rand();
    host.start_i = 1'b1;
    host.mode_i  = 1'b0;
    arr_done     = 1'b0;
    for (int t = 1; t <= b + d2 + 2; t++) begin
      step();
      rel = (t > b) ? t - b : t;
      eb_busy = (t <= d1) || (t > b && rel <= d2);
      eb_done = (t == d1 + 1) || (t == b + d2 + 1);
      n_cmp++;
      if ({host.busy_o, host.done_o, arr_start, arr_a, arr_b} !==
          {eb_busy, eb_done, rel == 2, exp_a(rel), exp_b(rel)}) begin
        n_bad++;
        $display("FAIL b2b t%0d: got %h want %h", t,
                 {host.busy_o, host.done_o, arr_start, arr_a, arr_b},
                 {eb_busy, eb_done, rel == 2, exp_a(rel), exp_b(rel)});
      end
      if (t == d1 + 1 || t == b + d2 + 1) begin
        exp_flags  = (t == d1 + 1) ? fl1 : fl2;
        exp_cycles = (t == d1 + 1) ? CW'(d1 - 2 * M) : CW'(d2 - 2 * M);
        n_cmp++;
        if (host.flags_o !== exp_flags || host.cycles_o !== exp_cycles) begin
          n_bad++;
          $display("FAIL b2b_result t%0d: got flags=%h cycles=%0d want flags=%h cycles=%0d", t,
                   host.flags_o, host.cycles_o, exp_flags, exp_cycles);
        end
      end
      host.start_i = (t <= b);
      arr_done     = (t == d1) || (t == b + d2);
      arr_flags    = (t == d1) ? fl1 : fl2;
    end
    host.start_i = 1'b0;
    arr_done     = 1'b0;
    $display("txn back_to_back done_at=%0d,%0d", d1 + 1, b + d2 + 1);
  endtask

  task automatic test_abort();
    int ab;
    logic mode, live;
    for (int r = 0; r < 6; r++) begin
      case (r)
        0: ab = 3;
        1: ab = 1;
        2: ab = 2 * M;
        3: ab = 2 * M + 1;
        4: ab = 2 * M + 5;
        default: ab = int'($urandom_range(1, 2 * M + 10));
      endcase
      load_rand();
      mode = 1'($urandom_range(0, 1));
      host.start_i = 1'b1;
      host.mode_i  = mode;
      host.abort_i = (r == 0);
      arr_done     = 1'b0;
      for (int t = 1; t <= ab + 4; t++) begin
        step();
        live = (t <= ab);
        n_cmp++;
        if ({host.busy_o, host.done_o, host.err_o, op_rd_en, arr_start, arr_mode, arr_a, arr_b} !==
            {live, 1'b0, 1'b0, live && t <= M, live && t == 2, live && mode,
             live ? exp_a(t) : BW'(0), live ? exp_b(t) : BW'(0)}) begin
          n_bad++;
          $display("FAIL abort r%0d t%0d: got %h want %h", r, t,
                   {host.busy_o, host.done_o, host.err_o, op_rd_en, arr_start, arr_mode, arr_a, arr_b},
                   {live, 1'b0, 1'b0, live && t <= M, live && t == 2, live && mode,
                    live ? exp_a(t) : BW'(0), live ? exp_b(t) : BW'(0)});
        end
        host.start_i = 1'b0;
        host.abort_i = (t == ab);
        arr_done     = (t == ab) && (r == 4);
        arr_flags    = FN'($urandom);
      end
      host.abort_i = 1'b0;
      arr_done     = 1'b0;
      n_cmp++;
      if (host.flags_o !== exp_flags || host.cycles_o !== exp_cycles) begin
        n_bad++;
        $display("FAIL abort_result r%0d: got flags=%h cycles=%0d want flags=%h cycles=%0d", r,
                 host.flags_o, host.cycles_o, exp_flags, exp_cycles);
      end
      $display("txn abort r=%0d abort_at=%0d", r, ab);
    end
  endtask

  task automatic test_reset_mid();
    load_rand();
    host.start_i = 1'b1;
    host.mode_i  = 1'b1;
    arr_done     = 1'b0;
    for (int t = 1; t <= 2 * M + 2; t++) begin
      step();
      n_cmp++;
      if (host.busy_o !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_mid_busy t%0d: got %b want 1", t, host.busy_o);
      end
      host.start_i = 1'b0;
    end
    rst_n     = 1'b0;
    arr_done  = 1'b1;
    arr_flags = '1;
    step();
    n_cmp++;
    if ({host.busy_o, host.done_o, host.err_o, host.flags_o, host.cycles_o, op_rd_en,
         op_addr, arr_a, arr_b, arr_start, arr_mode} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %h want 0", {host.busy_o, host.done_o, host.err_o,
               host.flags_o, host.cycles_o, op_rd_en, op_addr, arr_a, arr_b, arr_start, arr_mode});
    end
    rst_n      = 1'b1;
    arr_done   = 1'b0;
    exp_flags  = '0;
    exp_cycles = '0;
    for (int t = 0; t < 3; t++) begin
      step();
      n_cmp++;
      if ({host.busy_o, host.done_o, host.err_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_mid_after t%0d: got %b want 000", t, {host.busy_o, host.done_o, host.err_o});
      end
    end
    $display("txn reset_mid_wait");
  endtask

  initial begin
    host.start_i = 1'b0;
    host.mode_i  = 1'b0;
    host.abort_i = 1'b0;
    test_reset();
    test_feed_done();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_feed_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
